// File: rtl/rr_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// rr_arbiter_ctrl
//   Registered round-robin arbiter. One shared resource, WIDTH requesters.
//   The search for a winner starts just after the last winner. A winner keeps
//   its grant while it keeps requesting, up to MAX_HOLD cycles per tenure
//   (MAX_HOLD=0 means no limit). A released tenure is re-arbitrated on the
//   same edge, so there is no idle bubble between back-to-back grants.
//
// Ports
//   clk_i          rising-edge clock
//   rst_n_i        asynchronous active-low reset
//   en_i           1 = new grants may be issued (never cuts a live tenure)
//   req_i          request vector, bit i = requester i
//   grant_o        one-hot grant (registered)
//   grant_idx_o    binary index of the granted requester (registered)
//   grant_valid_o  1 while grant_o is nonzero (registered)
// ---------------------------------------------------------------------------

// Per-requester cell: the requester's position in the rotated search order.
// Rank 0 is the requester just after ptr; ptr itself ranks last.
module rr_arb_lane #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             req_i,
  output logic             cand_o,
  output logic [IDX_W-1:0] rank_o
);
  int r;

  always_comb begin
    r      = (LANE + WIDTH - 1 - int'(ptr_i)) % WIDTH;
    rank_o = IDX_W'(r);
    cand_o = req_i;
  end
endmodule

module rr_arbiter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o
);
  // Unlimited hold uses a wide saturating counter; otherwise the counter only
  // needs to reach MAX_HOLD-1.
  localparam int HOLD_W = (MAX_HOLD == 0) ? 8 :
                          ((MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1);

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } win_t;

  state_t                        state_q;
  logic [WIDTH-1:0]              grant_q;
  logic [IDX_W-1:0]              grant_idx_q;
  logic                          grant_valid_q;
  logic [IDX_W-1:0]              ptr_q;
  logic [HOLD_W-1:0]             hold_cnt_q;

  logic [WIDTH-1:0]              cand;
  logic [WIDTH-1:0][IDX_W-1:0]   rank;
  logic [IDX_W-1:0]              best_rank;
  win_t                          win_d;
  logic [WIDTH-1:0]              win_oh_d;
  logic                          hold_limit;
  logic                          release_d;

  // ---- winner search ----
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    rr_arb_lane #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W),
      .LANE  (g)
    ) u_lane (
      .ptr_i  (ptr_q),
      .req_i  (req_i[g]),
      .cand_o (cand[g]),
      .rank_o (rank[g])
    );
  end

  // Lowest rank among requesting lanes wins.
  always_comb begin
    win_d     = '0;
    best_rank = '1;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand[i] && (!win_d.found || rank[i] < best_rank)) begin
        win_d.found = 1'b1;
        win_d.idx   = IDX_W'(i);
        best_rank   = rank[i];
      end
    end
    win_oh_d = {{(WIDTH-1){1'b0}}, 1'b1} << win_d.idx;
  end

  // ---- tenure release ----
  // hold_cnt_q counts completed cycles of this tenure, so the last allowed
  // cycle is the one where it reads MAX_HOLD-1.
  always_comb begin
    hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
    release_d  = !req_i[grant_idx_q] || hold_limit;
  end

  // ---- control FSM with registered outputs ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= IDX_W'(WIDTH - 1);
      hold_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i && win_d.found) begin
            state_q       <= GRANT;
            grant_q       <= win_oh_d;
            grant_idx_q   <= win_d.idx;
            grant_valid_q <= 1'b1;
            ptr_q         <= win_d.idx;
            hold_cnt_q    <= '0;
          end else begin
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (!release_d) begin
            if (hold_cnt_q != '1) hold_cnt_q <= hold_cnt_q + 1'b1;
          end else if (en_i && win_d.found) begin
            // ptr_q equals the releasing winner here, so the search naturally
            // comes back to it only if nobody else is requesting.
            grant_q       <= win_oh_d;
            grant_idx_q   <= win_d.idx;
            grant_valid_q <= 1'b1;
            ptr_q         <= win_d.idx;
            hold_cnt_q    <= '0;
          end else begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= '0;
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_q       <= '0;
          grant_idx_q   <= '0;
          grant_valid_q <= 1'b0;
          hold_cnt_q    <= '0;
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
module tb_rr_arbiter_ctrl;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter_ctrl #(.WIDTH(4), .MAX_HOLD(8)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .en_i          (en),
    .req_i         (req),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;   // pulse reset before applying this vector
    logic       en;
    logic [3:0] req;
    logic [3:0] exp_g;
    string      tag;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst_b, input logic en_b,
                              input logic [3:0] req_b, input logic [3:0] g_b,
                              input string tag_b);
    vec_t v;
    v.rst = rst_b; v.en = en_b; v.req = req_b; v.exp_g = g_b; v.tag = tag_b;
    vq.push_back(v);
  endfunction

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] g);
    chk({name, ".grant"}, int'(grant), int'(g));
    chk({name, ".idx"}, int'(grant_idx), int'(oh2idx(g)));
    chk({name, ".valid"}, int'(grant_valid), int'(g != 4'b0000));
  endtask

  initial begin
    // ---------------- vector table ----------------
    // test 1: single requester, hold, drop, then rotation from ptr=1
    add(1, 1, 4'b0010, 4'b0010, "t1_first");
    for (int i = 0; i < 3; i++) add(0, 1, 4'b0010, 4'b0010, "t1_hold");
    add(0, 1, 4'b0000, 4'b0000, "t1_drop");
    add(0, 1, 4'b0000, 4'b0000, "t1_idle");
    add(0, 1, 4'b0011, 4'b0001, "t1_rot");     // search from 2 wraps to 0
    // test 2: all requesting, forced release every 8 cycles
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        add((k == 0 && i == 0), 1, 4'b1111, 4'b0001 << k, "t2_rr");
    add(0, 1, 4'b1111, 4'b0001, "t2_wrap");
    // test 3: winner drops early, no gap
    for (int i = 0; i < 3; i++) add(i == 0, 1, 4'b0111, 4'b0001, "t3_hold");
    add(0, 1, 4'b0110, 4'b0010, "t3_next");
    add(0, 1, 4'b0110, 4'b0010, "t3_next2");
    // test 4: lone requester re-wins through forced releases
    for (int i = 0; i < 20; i++) add(i == 0, 1, 4'b1000, 4'b1000, "t4_lone");
    // test 6: en gating
    for (int i = 0; i < 5; i++) add(i == 0, 0, 4'b0100, 4'b0000, "t6_blocked");
    add(0, 1, 4'b0100, 4'b0100, "t6_en");
    for (int i = 0; i < 3; i++) add(0, 0, 4'b0100, 4'b0100, "t6_persist");
    add(0, 0, 4'b0000, 4'b0000, "t6_drop");
    // en=0 during a tenure that hits the hold limit: ends, no re-grant
    add(0, 1, 4'b0100, 4'b0100, "t6b_start");
    for (int i = 0; i < 7; i++) add(0, 0, 4'b0100, 4'b0100, "t6b_hold");
    add(0, 0, 4'b0100, 4'b0000, "t6b_limit");
    add(0, 0, 4'b0100, 4'b0000, "t6b_idle");

    // ---------------- reset state ----------------
    rst_n = 1'b0; en = 1'b0; req = 4'b0000;
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 4'b0000);

    // ---------------- table run ----------------
    foreach (vq[n]) begin
      @(negedge clk);
      if (vq[n].rst) begin
        rst_n = 1'b0;
        #1 chk_all({vq[n].tag, ".rst"}, 4'b0000);
        rst_n = 1'b1;
      end else begin
        rst_n = 1'b1;
      end
      en  = vq[n].en;
      req = vq[n].req;
      @(posedge clk);
      #1 chk_all(vq[n].tag, vq[n].exp_g);
    end

    // ---------------- test 5: async reset mid-tenure ----------------
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    en = 1'b1; req = 4'b0100;
    @(posedge clk);
    #1 chk_all("t5_grant", 4'b0100);
    @(posedge clk);
    #1 chk_all("t5_hold", 4'b0100);
    #2 rst_n = 1'b0;                      // between edges
    #1 chk_all("t5_async", 4'b0000);      // cleared before any edge
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0101;
    @(posedge clk);
    #1 chk_all("t5_after", 4'b0001);      // ptr back to 3, so 0 wins

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
